// File: rtl/ao_pkg.sv
// Shared types and constants for the AND-OR evaluation arbiter.
// The operand vector layout is {p2d,p2c,p2b,p2a,p1f,p1e,p1d,p1c,p1b,p1a}.
package ao_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int OPND_W = 10;

  localparam int P1A = 0;
  localparam int P1B = 1;
  localparam int P1C = 2;
  localparam int P1D = 3;
  localparam int P1E = 4;
  localparam int P1F = 5;
  localparam int P2A = 6;
  localparam int P2B = 7;
  localparam int P2C = 8;
  localparam int P2D = 9;

endpackage

// File: rtl/ao_eval_unit.sv
// Combinational 7458-style AND-OR unit: a 3-input AND-OR section (p1)
// and a 2-input AND-OR section (p2).
module ao_eval_unit
  import ao_pkg::*;
(
  input  logic [OPND_W-1:0] opnd_i,
  output logic              p1y_o,
  output logic              p2y_o
);

  assign p1y_o = (opnd_i[P1A] & opnd_i[P1B] & opnd_i[P1C]) |
                 (opnd_i[P1D] & opnd_i[P1E] & opnd_i[P1F]);
  assign p2y_o = (opnd_i[P2A] & opnd_i[P2B]) |
                 (opnd_i[P2C] & opnd_i[P2D]);

endmodule

// File: rtl/ao_eval_arbiter.sv
// Round-robin arbiter sharing one AND-OR evaluation unit between N_REQ
// requesters; one request in flight, result held under valid/ready.
module ao_eval_arbiter
  import ao_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*OPND_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_p1y,
  output logic                    rsp_p2y,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_count
);

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OPND_W-1:0]   opnd_q;
  logic [ID_W-1:0]     own_id_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic                rsp_p1y_q, rsp_p2y_q;
  logic [CNT_W-1:0]    done_count_q;

  logic                found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     idx;
  logic [OPND_W-1:0]   win_opnd;
  logic                eval_p1y, eval_p2y;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
    rr_ptr_d = (int'(win_id) == N_REQ - 1) ? '0 : win_id + ID_W'(1);
  end

  assign win_opnd  = req_data[int'(win_id)*OPND_W +: OPND_W];
  // No accept is offered while reset is held, so nothing is lost.
  assign req_ready = (state_q == IDLE && found && !rst) ?
                     (N_REQ'(1) << win_id) : '0;

  ao_eval_unit u_eval (
    .opnd_i (opnd_q),
    .p1y_o  (eval_p1y),
    .p2y_o  (eval_p2y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      opnd_q       <= '0;
      own_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_p1y_q    <= 1'b0;
      rsp_p2y_q    <= 1'b0;
      done_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            opnd_q   <= win_opnd;
            own_id_q <= win_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EVAL;
          end
        end
        EVAL: begin
          rsp_p1y_q   <= eval_p1y;
          rsp_p2y_q   <= eval_p2y;
          rsp_id_q    <= own_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q  <= 1'b0;
            done_count_q <= done_count_q + CNT_W'(1);
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_p1y    = rsp_p1y_q;
  assign rsp_p2y    = rsp_p2y_q;
  assign busy       = (state_q != IDLE);
  assign done_count = done_count_q;

endmodule

// File: tb/tb_ao_eval_arbiter.sv
// Bench for ao_eval_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model (one outstanding job with a due cycle).
module tb_ao_eval_arbiter;

  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*10-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_p1y;
  logic            rsp_p2y;
  logic            busy;
  logic [CNT_W-1:0] done_count;

  ao_eval_arbiter #(.N_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_p1y    (rsp_p1y),
    .rsp_p2y    (rsp_p2y),
    .busy       (busy),
    .done_count (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: at most one job outstanding, result due two cycles after grant.
  int          cyc    = 0;
  bit          m_have = 0;
  int          m_due  = 0;
  int          m_id   = 0;
  bit          m_p1   = 0;
  bit          m_p2   = 0;
  int          m_ptr  = 0;
  logic [15:0] m_cnt  = 0;

  function automatic int pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic bit ref_p1(input logic [9:0] o);
    return (o[0] && o[1] && o[2]) || (o[3] && o[4] && o[5]);
  endfunction

  function automatic bit ref_p2(input logic [9:0] o);
    return (o[6] && o[7]) || (o[8] && o[9]);
  endfunction

  task automatic step(input bit r, input logic [N-1:0] v, input logic [N*10-1:0] d,
                      input bit rr);
    int          w;
    logic [N-1:0] exp_ready;
    bit          exp_rv;
    logic [9:0]  slice;
    @(negedge clk);
    rst = r; req_valid = v; req_data = d; rsp_ready = rr;
    #1;
    w = pick(m_ptr, v);
    exp_ready = '0;
    if (!m_have && !r && w >= 0) exp_ready[w] = 1'b1;
    exp_rv = m_have && (cyc >= m_due);
    check("req_ready",  32'(req_ready),  32'(exp_ready));
    check("busy",       32'(busy),       32'(m_have));
    check("rsp_valid",  32'(rsp_valid),  32'(exp_rv));
    check("done_count", 32'(done_count), 32'(m_cnt));
    if (exp_rv) begin
      check("rsp_id",  32'(rsp_id),  32'(m_id));
      check("rsp_p1y", 32'(rsp_p1y), 32'(m_p1));
      check("rsp_p2y", 32'(rsp_p2y), 32'(m_p2));
    end
    if (r) begin
      m_have = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_have && w >= 0) begin
      slice  = d[w*10 +: 10];
      m_have = 1; m_due = cyc + 2; m_id = w;
      m_p1   = ref_p1(slice); m_p2 = ref_p2(slice);
      m_ptr  = (w + 1) % N;
    end else if (exp_rv && rr) begin
      m_have = 0; m_cnt = m_cnt + 16'd1;
    end
    cyc++;
  endtask

  function automatic logic [N*10-1:0] rnd_data();
    return {8'($urandom), 32'($urandom)};
  endfunction

  logic [9:0] pats [4] = '{10'h0C0, 10'h038, 10'h015, 10'h3FF};

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);

    // single request from requester 2
    repeat (5) step(0, 4'b0100, 40'h03F << 20, 1);
    check("p1y_03F", 32'(ref_p1(10'h03F)), 32'd1);

    // truth spot checks through requester 0
    foreach (pats[i]) repeat (4) step(0, 4'b0001, {30'h0, pats[i]}, 1);

    // fairness with all valid
    step(1, '0, '0, 1);
    repeat (19) step(0, 4'b1111, rnd_data(), 1);

    // pointer skip
    step(1, '0, '0, 1);
    repeat (3) step(0, 4'b0001, rnd_data(), 1);
    repeat (7) step(0, 4'b1001, rnd_data(), 1);

    // back-pressure
    repeat (3) step(0, 4'b1111, rnd_data(), 1);
    repeat (6) step(0, 4'b1111, rnd_data(), 0);
    repeat (6) step(0, 4'b1111, rnd_data(), 1);

    // reset mid-EVAL
    step(1, '0, '0, 1);
    step(0, 4'b1111, rnd_data(), 1);
    step(1, 4'b1111, rnd_data(), 1);
    repeat (4) step(0, 4'b0110, rnd_data(), 1);

    // reset mid-RESP
    step(0, 4'b1111, rnd_data(), 0);
    step(0, 4'b1111, rnd_data(), 0);
    step(0, 4'b1111, rnd_data(), 0);
    step(1, 4'b1111, rnd_data(), 0);
    repeat (4) step(0, 4'b0110, rnd_data(), 1);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, N'($urandom), rnd_data(),
           $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
